// File: rtl/shift_add_mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package shift_add_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_add_stage.sv
// Combinational WIDTH-bit adder without carry-in; the carry-out carries the
// multiplier's extra accumulator bit.
module mul_add_stage #(
  parameter int WIDTH = shift_add_mul_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Optional early termination on exhausted multiplier bits: SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addSum;
  logic               addCout;
  logic [WIDTH:0]     stepSum;

  mul_add_stage #(.WIDTH(WIDTH)) u_add (
    .a    (acc_q),
    .b    (mcand_q),
    .sum  (addSum),
    .cout (addCout)
  );

  // Skipped additions keep a zero carry so the shift stays 2*WIDTH bits wide.
  assign stepSum = mplier_q[0] ? {addCout, addSum} : {1'b0, acc_q};

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]   remainBits;
  logic [CntW:0]      shamt;
  logic [2*WIDTH-1:0] aligned;

  // Consumed bits have been shifted out the top; only low WIDTH-count remain.
  assign remainBits = mplier_q << count_q;
  assign shamt      = (CntW+1)'(WIDTH) - {1'b0, count_q};
  assign aligned    = {acc_q, mplier_q} >> shamt;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d  = a;
          acc_d    = '0;
          mplier_d = b;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        if (remainBits == '0) begin
          product_d = aligned;
          state_d   = DONE;
        end else begin
          {acc_d, mplier_d} = {stepSum, mplier_q[WIDTH-1:1]};
          count_d           = count_q + 1'b1;
          if (count_q == CntW'(WIDTH-1)) begin
            product_d = {stepSum, mplier_q[WIDTH-1:1]};
            state_d   = DONE;
          end
        end
`else
        {acc_d, mplier_d} = {stepSum, mplier_q[WIDTH-1:1]};
        count_d           = count_q + 1'b1;
        if (count_q == CntW'(WIDTH-1)) begin
          product_d = {stepSum, mplier_q[WIDTH-1:1]};
          state_d   = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
